// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared types and constants for the sequential binary-to-BCD path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX    = 9999;
    localparam int DIGIT_W    = 4;

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module   : bcd_add3
// Purpose  : Double-dabble nibble corrector; adds 3 when the digit is >= 5.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_i,
    output logic [DIGIT_W-1:0] y_o
);

    assign y_o = (a_i >= DIGIT_W'(5)) ? (a_i + DIGIT_W'(3)) : a_i;

endmodule

`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential shift-and-add-3 converter feeding the 4-digit display.
//            Optional macro BCD_SIGNED_INPUT_EN treats value as two's complement.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH = 14
)(
    input  logic             clk_main,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [3:0]       num_1,
    output logic [3:0]       num_2,
    output logic [3:0]       num_3,
    output logic [3:0]       num_4,
    output logic             neg,
    output logic             ovf
);

    localparam int BCD_W = BCD_DIGITS * DIGIT_W;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               ovf_lat_q, ovf_lat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   w_mag;
    logic               w_sign;
    logic               w_ovf;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [SR_W-1:0]    w_sr_next;

`ifdef BCD_SIGNED_INPUT_EN
    // Negating the most negative code yields 2^(WIDTH-1), which still fits unsigned.
    assign w_sign = value[WIDTH-1];
    assign w_mag  = w_sign ? (~value + WIDTH'(1)) : value;
`else
    assign w_sign = 1'b0;
    assign w_mag  = value;
`endif

    assign w_ovf = (32'(w_mag) > 32'(BCD_MAX));

    generate
        for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .a_i (sr_q[WIDTH + g*DIGIT_W +: DIGIT_W]),
                .y_o (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // Carries out of the BCD field are dropped; overflow was decided at capture.
    assign w_sr_next = {w_bcd_adj, sr_q[WIDTH-1:0]} << 1;

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        ovf_lat_d = ovf_lat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        digits_d  = digits_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = {{BCD_W{1'b0}}, w_mag};
                    cnt_d     = CNT_W'(WIDTH);
                    sign_d    = w_sign;
                    ovf_lat_d = w_ovf;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = w_sr_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                digits_d = ovf_lat_q ? 16'h9999 : sr_q[SR_W-1:WIDTH];
                neg_d    = sign_q;
                ovf_d    = ovf_lat_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            ovf_lat_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            digits_q  <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            ovf_lat_q <= ovf_lat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            digits_q  <= digits_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign num_1 = digits_q[3:0];
    assign num_2 = digits_q[7:4];
    assign num_3 = digits_q[11:8];
    assign num_4 = digits_q[15:12];
    assign neg   = neg_q;
    assign ovf   = ovf_q;

endmodule

`default_nettype wire
